exe_lsu_multi_outstanding: RTL

- Parametrised successor of the single-request EXE-stage load/store unit.
- Accepts load, store and AMO ops from the execute stage and generates the effective address.
- Holds up to DEPTH in-flight D-cache requests, tagged by entry, with out-of-order responses, NACK replay and a global flush.
- Sits between the EXE issue logic and the D-cache request/response port; returns load/AMO data to WB.

---
 rtl/exe_lsu_multi_outstanding.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/exe_lsu_multi_outstanding.sv
// EXE-stage load/store unit with DEPTH outstanding D-cache requests, OoO responses, NACK replay and flush.
// Optional alignment check at acceptance, enabled by `define LSU_MISALIGN_CHECK_EN.
module exe_lsu_multi_outstanding #(
  parameter int ADDR_W = 40,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int TAG_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WB_EXCEPTION,
  input  logic              CSR_ERET,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              LOAD,
  input  logic              STORE,
  input  logic              AMO,
  input  logic [4:0]        AMO_FUNCT,
  input  logic [2:0]        FUNCT3,
  input  logic [11:0]       IMM,
  input  logic [DATA_W-1:0] SOURCE1,
  input  logic [DATA_W-1:0] SOURCE2,
  input  logic [4:0]        DST,
  input  logic [ADDR_W-1:0] IO_BASE_ADDR,
  input  logic [ADDR_W-1:0] IO_LIMIT_ADDR,
  output logic              DMEM_REQ_VALID,
  input  logic              DMEM_REQ_READY,
  output logic [4:0]        DMEM_REQ_CMD,
  output logic [ADDR_W-1:0] DMEM_REQ_ADDR,
  output logic [DATA_W-1:0] DMEM_REQ_DATA,
  output logic [3:0]        DMEM_REQ_TYPE,
  output logic [TAG_W-1:0]  DMEM_REQ_TAG,
  output logic              DMEM_REQ_KILL,
  input  logic              DMEM_RESP_VALID,
  input  logic [TAG_W-1:0]  DMEM_RESP_TAG,
  input  logic              DMEM_RESP_NACK,
  input  logic [DATA_W-1:0] DMEM_RESP_DATA,
  input  logic              DMEM_XCPT,
  output logic              MEM_READY,
  output logic [DATA_W-1:0] MEM_DATA,
  output logic [4:0]        WRITE_ADDR,
`ifdef LSU_MISALIGN_CHECK_EN
  output logic              MISALIGN_XCPT,
  output logic [ADDR_W-1:0] MISALIGN_ADDR,
`endif
  output logic              LSU_EMPTY
);

  localparam logic [4:0] M_XRD = 5'b00000, M_XWR = 5'b00001;

  typedef enum logic [1:0] {FREE, PENDING, ISSUED} ent_state_e;

  ent_state_e        st_q    [DEPTH];
  logic [4:0]        cmd_q   [DEPTH];
  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [3:0]        type_q  [DEPTH];
  logic [4:0]        dst_q   [DEPTH];
  logic              io_q    [DEPTH];
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic              epoch_q, last_fire_q;
  logic [IDX_W-1:0]  last_idx_q;

  logic              flush, full, iss_vld, older_pend, req_fire, dmem_fire, resp_hit, misalign;
  logic [IDX_W-1:0]  free_idx, iss_idx, resp_idx;
  logic [ADDR_W-1:0] agu_addr;
  logic [4:0]        amo_cmd, new_cmd;
  logic [TAG_W-1:0]  exp_tag;
  logic              unused_src1_hi;

  assign unused_src1_hi = ^SOURCE1[DATA_W-1:ADDR_W];

  assign flush    = WB_EXCEPTION | CSR_ERET;
  assign agu_addr = AMO ? SOURCE1[ADDR_W-1:0]
                        : SOURCE1[ADDR_W-1:0] + {{(ADDR_W-12){IMM[11]}}, IMM};

  always_comb begin
    case (AMO_FUNCT)
      5'b00010: amo_cmd = 5'b00110;
      5'b00011: amo_cmd = 5'b00111;
      5'b00001: amo_cmd = 5'b00100;
      5'b00000: amo_cmd = 5'b01000;
      5'b00100: amo_cmd = 5'b01001;
      5'b01000: amo_cmd = 5'b01010;
      5'b01100: amo_cmd = 5'b01011;
      5'b10000: amo_cmd = 5'b01100;
      5'b10100: amo_cmd = 5'b01101;
      5'b11000: amo_cmd = 5'b01110;
      5'b11100: amo_cmd = 5'b01111;
      default:  amo_cmd = M_XRD;
    endcase
    new_cmd = AMO ? amo_cmd : (STORE ? M_XWR : M_XRD);
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    case (FUNCT3[1:0])
      2'b01:   misalign = agu_addr[0];
      2'b10:   misalign = |agu_addr[1:0];
      2'b11:   misalign = |agu_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Lowest free slot for allocation; oldest pending slot (no older pending peer) for issue.
  always_comb begin
    full       = 1'b1;
    free_idx   = '0;
    iss_vld    = 1'b0;
    iss_idx    = '0;
    older_pend = 1'b0;
    LSU_EMPTY  = 1'b1;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (st_q[DEPTH-1-k] == FREE) begin
        full     = 1'b0;
        free_idx = IDX_W'(DEPTH-1-k);
      end
      if (st_q[k] != FREE) LSU_EMPTY = 1'b0;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      older_pend = 1'b0;
      for (int unsigned j = 0; j < DEPTH; j++)
        if (j != i && st_q[j] == PENDING && older_q[j][i]) older_pend = 1'b1;
      if (st_q[i] == PENDING && !older_pend && !iss_vld) begin
        iss_vld = 1'b1;
        iss_idx = IDX_W'(i);
      end
    end
  end

  assign REQ_READY      = ~full & ~flush;
  assign req_fire       = REQ_VALID & REQ_READY & (LOAD | STORE | AMO) & ~misalign;
  assign DMEM_REQ_VALID = iss_vld & ~flush;
  assign dmem_fire      = DMEM_REQ_VALID & DMEM_REQ_READY;
  assign DMEM_REQ_CMD   = cmd_q[iss_idx];
  assign DMEM_REQ_ADDR  = addr_q[iss_idx];
  assign DMEM_REQ_DATA  = data_q[iss_idx];
  assign DMEM_REQ_TYPE  = type_q[iss_idx];
  assign DMEM_REQ_KILL  = DMEM_XCPT | (flush & last_fire_q);
  assign resp_idx       = DMEM_RESP_TAG[IDX_W-1:0];

  always_comb begin
    DMEM_REQ_TAG             = '0;
    DMEM_REQ_TAG[IDX_W:0]    = {epoch_q, iss_idx};
    exp_tag                  = '0;
    exp_tag[IDX_W:0]         = {epoch_q, resp_idx};
  end

  assign resp_hit   = DMEM_RESP_VALID & (DMEM_RESP_TAG == exp_tag) & (st_q[resp_idx] == ISSUED);
  assign MEM_READY  = resp_hit & ~DMEM_RESP_NACK & (cmd_q[resp_idx] != M_XWR);
  assign MEM_DATA   = DMEM_RESP_DATA;
  assign WRITE_ADDR = dst_q[resp_idx];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        st_q[i]    <= FREE;
        cmd_q[i]   <= '0;
        addr_q[i]  <= '0;
        data_q[i]  <= '0;
        type_q[i]  <= '0;
        dst_q[i]   <= '0;
        io_q[i]    <= 1'b0;
        older_q[i] <= '0;
      end
      epoch_q     <= 1'b0;
      last_fire_q <= 1'b0;
      last_idx_q  <= '0;
    end else begin
      last_fire_q <= dmem_fire;
      last_idx_q  <= iss_idx;
      if (flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) st_q[i] <= FREE;
        epoch_q <= ~epoch_q;
      end else begin
        if (dmem_fire) st_q[iss_idx] <= io_q[iss_idx] ? FREE : ISSUED;
        if (resp_hit)  st_q[resp_idx] <= DMEM_RESP_NACK ? PENDING : FREE;
        if (DMEM_XCPT && last_fire_q && st_q[last_idx_q] == ISSUED) st_q[last_idx_q] <= FREE;
        if (req_fire) begin
          st_q[free_idx]   <= PENDING;
          cmd_q[free_idx]  <= new_cmd;
          addr_q[free_idx] <= agu_addr;
          data_q[free_idx] <= (STORE | AMO) ? SOURCE2 : '0;
          type_q[free_idx] <= {1'b0, FUNCT3};
          dst_q[free_idx]  <= DST;
          io_q[free_idx]   <= STORE & (agu_addr >= IO_BASE_ADDR) & (agu_addr <= IO_LIMIT_ADDR);
          for (int unsigned j = 0; j < DEPTH; j++) begin
            older_q[free_idx][j] <= 1'b0;
            if (IDX_W'(j) != free_idx) older_q[j][free_idx] <= 1'b1;
          end
        end
      end
    end
  end

`ifdef LSU_MISALIGN_CHECK_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      MISALIGN_XCPT <= 1'b0;
      MISALIGN_ADDR <= '0;
    end else begin
      MISALIGN_XCPT <= REQ_VALID & REQ_READY & (LOAD | STORE | AMO) & misalign;
      MISALIGN_ADDR <= agu_addr;
    end
  end
`endif

endmodule
